// File: rtl/mode4_tree_feeder_if.sv
// Bus between the mode-4 tree feeder, its buffer RAM and the 4-input adder tree.
// The master modport is the feeder's view; the slave modport is the
// environment's view (buffer RAM, adder tree, requester).
// Optional macro MODE4_FEEDER_HOLD_EN adds the feed_hold stall input.
interface mode4_tree_feeder_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
);
   logic                    start;
   logic                    rd_en;
   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic [4*DATA_WIDTH-1:0] rd_data;
   logic [DATA_WIDTH-1:0]   inp0;
   logic [DATA_WIDTH-1:0]   inp1;
   logic [DATA_WIDTH-1:0]   inp2;
   logic [DATA_WIDTH-1:0]   inp3;
   logic                    mode4_stage2_run;
   logic                    mode4_stage1_run;
   logic                    mode4_stage0_run;
   logic                    tree_reset;
   logic [DATA_WIDTH-1:0]   tree_outp;
   logic [DATA_WIDTH-1:0]   result_data;
   logic                    done;
   logic                    busy;
`ifdef MODE4_FEEDER_HOLD_EN
   logic                    feed_hold;

   modport master (
      input  start, rd_data, tree_outp, feed_hold,
      output rd_en, rd_addr, inp0, inp1, inp2, inp3,
             mode4_stage2_run, mode4_stage1_run, mode4_stage0_run,
             tree_reset, result_data, done, busy
   );

   modport slave (
      output start, rd_data, tree_outp, feed_hold,
      input  rd_en, rd_addr, inp0, inp1, inp2, inp3,
             mode4_stage2_run, mode4_stage1_run, mode4_stage0_run,
             tree_reset, result_data, done, busy
   );
`else
   modport master (
      input  start, rd_data, tree_outp,
      output rd_en, rd_addr, inp0, inp1, inp2, inp3,
             mode4_stage2_run, mode4_stage1_run, mode4_stage0_run,
             tree_reset, result_data, done, busy
   );

   modport slave (
      output start, rd_data, tree_outp,
      input  rd_en, rd_addr, inp0, inp1, inp2, inp3,
             mode4_stage2_run, mode4_stage1_run, mode4_stage0_run,
             tree_reset, result_data, done, busy
   );
`endif
endinterface

// File: rtl/mode4_tree_feeder.sv
// Initiator/sequencer for the 4-input mode-4 adder tree.
// Clears the tree, streams VECTOR_DEPTH/4 buffer words into the four tree
// lanes, walks the stage2/stage1/stage0 run enables down a 3-deep shift
// register in step with the data, then captures the reduced sum.
// Optional macro MODE4_FEEDER_HOLD_EN: feed_hold stalls word issue in READ.
module mode4_tree_feeder #(
   parameter int DATA_WIDTH   = 16,
   parameter int VECTOR_DEPTH = 64,
   parameter int ADDR_WIDTH   = 4
) (
   input  logic               clk,
   input  logic               reset,
   mode4_tree_feeder_if.master bus
);
   localparam int BEATS = VECTOR_DEPTH / 4;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BEATS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      READ  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                  state_r;
   logic                    rd_en_r;
   logic [ADDR_WIDTH-1:0]   rd_addr_r;
   // run_r[0]=stage2, run_r[1]=stage1, run_r[2]=stage0
   logic [2:0]              run_r;
   logic                    tree_reset_r;
   logic                    done_r;
   logic                    busy_r;
   logic [DATA_WIDTH-1:0]   result_r;

   // Sequencer FSM, run-enable pipeline and all registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r      <= IDLE;
         rd_en_r      <= 1'b0;
         rd_addr_r    <= '0;
         run_r        <= 3'b000;
         tree_reset_r <= 1'b1;
         done_r       <= 1'b0;
         busy_r       <= 1'b0;
         result_r     <= '0;
      end else begin
         // every issued read becomes a stage2 run one cycle later, when its data lands
         run_r <= {run_r[1:0], rd_en_r};
         case (state_r)
            IDLE: begin
               rd_en_r <= 1'b0;
               done_r  <= 1'b0;
               if (bus.start) begin
                  tree_reset_r <= 1'b1;
                  busy_r       <= 1'b1;
                  state_r      <= CLEAR;
               end else begin
                  tree_reset_r <= 1'b0;
                  busy_r       <= 1'b0;
               end
            end
            CLEAR: begin
               tree_reset_r <= 1'b0;
               rd_en_r      <= 1'b1;
               rd_addr_r    <= '0;
               state_r      <= READ;
            end
            READ: begin
               // rd_addr always holds the most recently issued word address
               if (rd_en_r && (rd_addr_r == LAST_ADDR)) begin
                  rd_en_r   <= 1'b0;
                  rd_addr_r <= '0;
                  state_r   <= DRAIN;
`ifdef MODE4_FEEDER_HOLD_EN
               end else if (bus.feed_hold) begin
                  rd_en_r <= 1'b0;
`endif
               end else begin
                  rd_en_r   <= 1'b1;
                  rd_addr_r <= rd_addr_r + ADDR_WIDTH'(1);
               end
            end
            DRAIN: begin
               // once the pipe is empty, tree_outp already includes the last stage0 update
               if (run_r == 3'b000) begin
                  result_r <= bus.tree_outp;
                  done_r   <= 1'b1;
                  state_r  <= DONE;
               end else begin
                  state_r <= DRAIN;
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               state_r      <= IDLE;
               rd_en_r      <= 1'b0;
               rd_addr_r    <= '0;
               tree_reset_r <= 1'b1;
               done_r       <= 1'b0;
               busy_r       <= 1'b0;
            end
         endcase
      end
   end

   // tree lanes are straight slices of the buffer word
   assign bus.inp0 = bus.rd_data[0*DATA_WIDTH +: DATA_WIDTH];
   assign bus.inp1 = bus.rd_data[1*DATA_WIDTH +: DATA_WIDTH];
   assign bus.inp2 = bus.rd_data[2*DATA_WIDTH +: DATA_WIDTH];
   assign bus.inp3 = bus.rd_data[3*DATA_WIDTH +: DATA_WIDTH];

   assign bus.rd_en            = rd_en_r;
   assign bus.rd_addr          = rd_addr_r;
   assign bus.mode4_stage2_run = run_r[0];
   assign bus.mode4_stage1_run = run_r[1];
   assign bus.mode4_stage0_run = run_r[2];
   assign bus.tree_reset       = tree_reset_r;
   assign bus.result_data      = result_r;
   assign bus.done             = done_r;
   assign bus.busy             = busy_r;
endmodule

// File: tb/tb_mode4_tree_feeder.sv
// Self-checking bench for mode4_tree_feeder: buffer RAM model, behavioural
// mode-4 adder tree, and a scoreboard of expected vector sums.
module tb_mode4_tree_feeder;
   localparam int DW    = 16;
   localparam int VD    = 64;
   localparam int AW    = 4;
   localparam int BEATS = VD / 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mode4_tree_feeder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   mode4_tree_feeder #(.DATA_WIDTH(DW), .VECTOR_DEPTH(VD), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [DW-1:0] sb_q[$];
   logic [DW-1:0] last_res;
   logic [4*DW-1:0] mem [BEATS];

   // buffer RAM: one-cycle read latency
   always @(posedge clk) begin
      if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
   end

   function automatic logic [DW-1:0] sadd(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW:0] t;
      t = {1'b0, a} + {1'b0, b};
      return t[DW] ? 16'h7000 : t[DW-1:0];
   endfunction

   // behavioural adder tree: pair adds, pair-sum add, accumulate
   logic [DW-1:0] s2a, s2b, s1, acc;
   always @(posedge clk) begin
      if (bus.tree_reset) begin
         s2a <= '0; s2b <= '0; s1 <= '0; acc <= '0;
      end else begin
         if (bus.mode4_stage2_run) begin
            s2a <= sadd(bus.inp0, bus.inp1);
            s2b <= sadd(bus.inp2, bus.inp3);
         end
         if (bus.mode4_stage1_run) s1 <= sadd(s2a, s2b);
         if (bus.mode4_stage0_run) acc <= sadd(acc, s1);
      end
   end
   assign bus.tree_outp = acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // kind 0: all ones, 1: element i = i, 2: all twos
   task automatic fill_mem(input int kind);
      for (int w = 0; w < BEATS; w++) begin
         for (int k = 0; k < 4; k++) begin
            mem[w][k*DW +: DW] = (kind == 1) ? DW'(4*w + k) : ((kind == 0) ? 16'h0001 : 16'h0002);
         end
      end
   endtask

   function automatic logic [DW-1:0] ref_sum();
      logic [DW-1:0] s;
      s = '0;
      for (int w = 0; w < BEATS; w++) begin
         for (int k = 0; k < 4; k++) s = s + mem[w][k*DW +: DW];
      end
      return s;
   endfunction

   // One full vector from start; cycle k is the interval after edge k-1, start sampled at edge 0.
   task automatic run_vec(input string name, input int hold_lo, input int hold_hi, input bit poke);
      int h = (hold_hi >= hold_lo) ? (hold_hi - hold_lo + 1) : 0;
      int n_tr = 0, tr_cyc = -1, first_rd = -1, last_rd = -1, n_rd = 0, addr_err = 0, exp_addr = 0;
      int n_s0 = 0, last_s0 = -1, align_err = 0, n_done = 0, done_cyc = -1, busy_err = 0, hold_err = 0;
      logic prev_rd = 1'b0, prev_s2 = 1'b0, prev_s1 = 1'b0;
      logic [DW-1:0] expv;
      @(negedge clk);
      bus.start = 1'b1;
      sb_q.push_back(ref_sum());
      for (int k = 1; k <= BEATS + 12 + h; k++) begin
         @(negedge clk);
         bus.start = poke && (k == 8);
`ifdef MODE4_FEEDER_HOLD_EN
         bus.feed_hold = (k >= hold_lo) && (k <= hold_hi);
`endif
         if (bus.tree_reset) begin n_tr++; tr_cyc = k; end
         if (bus.rd_en) begin
            if (first_rd < 0) first_rd = k;
            last_rd = k;
            n_rd++;
            if (bus.rd_addr !== AW'(exp_addr)) addr_err++;
            exp_addr++;
         end
         if (bus.mode4_stage2_run !== prev_rd || bus.mode4_stage1_run !== prev_s2 ||
             bus.mode4_stage0_run !== prev_s1) align_err++;
         prev_rd = bus.rd_en;
         prev_s2 = bus.mode4_stage2_run;
         prev_s1 = bus.mode4_stage1_run;
         if (bus.mode4_stage0_run) begin n_s0++; last_s0 = k; end
         if (bus.done) begin
            n_done++;
            done_cyc = k;
            chk({name, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
            if (sb_q.size() > 0) begin
               expv = sb_q.pop_front();
               chk({name, "_result"}, 32'(bus.result_data), 32'(expv));
               last_res = expv;
            end
            if (poke) bus.start = 1'b1;
         end else if (bus.result_data !== last_res) begin
            hold_err++;
         end
         if (bus.busy !== ((done_cyc < 0) || (k == done_cyc))) busy_err++;
      end
      bus.start = 1'b0;
`ifdef MODE4_FEEDER_HOLD_EN
      bus.feed_hold = 1'b0;
`endif
      chk({name, "_tree_reset_cnt"}, n_tr, 1);
      chk({name, "_tree_reset_cyc"}, tr_cyc, 1);
      chk({name, "_first_rd"}, first_rd, 2);
      chk({name, "_last_rd"}, last_rd, BEATS + 1 + h);
      chk({name, "_rd_cnt"}, n_rd, BEATS);
      chk({name, "_addr_err"}, addr_err, 0);
      chk({name, "_align_err"}, align_err, 0);
      chk({name, "_s0_cnt"}, n_s0, BEATS);
      chk({name, "_last_s0"}, last_s0, BEATS + 4 + h);
      chk({name, "_done_cnt"}, n_done, 1);
      chk({name, "_done_cyc"}, done_cyc, BEATS + 6 + h);
      chk({name, "_busy_err"}, busy_err, 0);
      chk({name, "_result_hold_err"}, hold_err, 0);
   endtask

   initial begin
      int n_done;
      int n_busy;
      reset = 1'b0;
      bus.start = 1'b0;
`ifdef MODE4_FEEDER_HOLD_EN
      bus.feed_hold = 1'b0;
`endif
      last_res = '0;
      repeat (3) @(negedge clk);
      chk("rst_rd_en", 32'(bus.rd_en), 32'd0);
      chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
      chk("rst_runs", 32'({bus.mode4_stage0_run, bus.mode4_stage1_run, bus.mode4_stage2_run}), 32'd0);
      chk("rst_done_busy", 32'({bus.done, bus.busy}), 32'd0);
      chk("rst_result", 32'(bus.result_data), 32'd0);
      chk("rst_tree_reset", 32'(bus.tree_reset), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("rel_tree_reset", 32'(bus.tree_reset), 32'd0);

      fill_mem(0);
      run_vec("ones", 0, -1, 1'b0);
      fill_mem(1);
      run_vec("index", 0, -1, 1'b0);
      fill_mem(0);
      run_vec("b2b_ones", 0, -1, 1'b0);
      fill_mem(2);
      run_vec("b2b_twos", 0, -1, 1'b0);
      fill_mem(0);
      run_vec("poke", 0, -1, 1'b1);

      // reset in cycle 10 of a run aborts it
      fill_mem(1);
      @(negedge clk);
      bus.start = 1'b1;
      sb_q.push_back(ref_sum());
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (k == 10) reset = 1'b0;
      end
      @(negedge clk);
      chk("abort_rd_en_addr", 32'({bus.rd_en, bus.rd_addr}), 32'd0);
      chk("abort_runs", 32'({bus.mode4_stage0_run, bus.mode4_stage1_run, bus.mode4_stage2_run}), 32'd0);
      chk("abort_done_busy", 32'({bus.done, bus.busy}), 32'd0);
      chk("abort_result", 32'(bus.result_data), 32'd0);
      chk("abort_tree_reset", 32'(bus.tree_reset), 32'd1);
      chk("abort_sb_depth", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      last_res = '0;
      reset = 1'b1;
      n_done = 0;
      n_busy = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (bus.done) n_done++;
         if (bus.busy) n_busy++;
      end
      chk("abort_no_done", n_done, 0);
      chk("abort_no_busy", n_busy, 0);
      run_vec("after_abort", 0, -1, 1'b0);

`ifdef MODE4_FEEDER_HOLD_EN
      fill_mem(0);
      run_vec("hold", 5, 7, 1'b0);
`endif

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mode4_tree_feeder.md
Name: mode4_tree_feeder

Overview:
- Initiator and sequencer for the 4-input mode-4 adder tree: 4-lane reduce tree, stage2/stage1/stage0 run enables, outp accumulator that clears only on tree reset.
- Reads a VECTOR_DEPTH-element vector from a buffer RAM, 4 elements per word, and drives the tree lanes and the three stage-run enables in pipeline order.
- Clears the tree accumulator before each vector, then captures the final reduced sum and signals done.
- Sits between the Q/K/V buffer RAMs and the adder tree in the attention datapath.

Parameters:
DATA_WIDTH, 16, width of one element and of each tree lane
VECTOR_DEPTH, 64, elements per vector; must be a multiple of 4
ADDR_WIDTH, 4, buffer address width; 2**ADDR_WIDTH >= VECTOR_DEPTH/4

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
start  input  1  one-cycle request to reduce one vector; sampled only in IDLE
rd_en  output  1  buffer read strobe
rd_addr  output  ADDR_WIDTH  buffer word address
rd_data  input  4*DATA_WIDTH  buffer word, valid exactly 1 cycle after rd_en; element k in bits [k*DATA_WIDTH +: DATA_WIDTH]
inp0..inp3  output  DATA_WIDTH each  tree lanes, combinational slices 0..3 of rd_data
mode4_stage2_run  output  1  tree stage2 enable
mode4_stage1_run  output  1  tree stage1 enable
mode4_stage0_run  output  1  tree stage0 (accumulate) enable
tree_reset  output  1  active-high synchronous reset to the tree
tree_outp  input  DATA_WIDTH  tree accumulator output
result_data  output  DATA_WIDTH  captured vector sum
done  output  1  one-cycle completion pulse
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (reset==0 at a clock edge):
  - FSM goes to IDLE.
  - rd_en, rd_addr, all run enables, done, busy and result_data are 0.
  - tree_reset is 1, so the tree is held cleared while this block is in reset.
  - tree_reset drops to 0 on the first edge after reset is released.
- Reset mid-operation: abort immediately with the same values; in-flight run pipeline bits are cleared and no done pulse is produced.
- FSM IDLE:
  - start==1 -> CLEAR.
  - busy=0; result_data holds its last value.
- FSM CLEAR: exactly one cycle; tree_reset=1 -> READ.
- FSM READ:
  - rd_en=1 each cycle; rd_addr counts 0..BEATS-1, where BEATS=VECTOR_DEPTH/4.
  - After issuing addr BEATS-1 -> DRAIN; addr counter returns to 0.
- Run pipeline: 3-bit shift register fed by the issued rd_en.
  - mode4_stage2_run = rd_en delayed 1 cycle, aligned with rd_data.
  - mode4_stage1_run = rd_en delayed 2 cycles.
  - mode4_stage0_run = rd_en delayed 3 cycles.
  - Bubbles propagate as 0.
- FSM DRAIN:
  - Wait until the shift register is empty and one more cycle has passed, so tree_outp reflects the last stage0 update.
  - Then capture tree_outp into result_data -> DONE.
- FSM DONE: done=1 for one cycle -> IDLE.
- start while busy, including in DONE, is ignored and not queued.
- Timing with start sampled at edge 0:
  - tree_reset high in cycle 1.
  - rd_en in cycles 2..BEATS+1.
  - stage0_run ends in cycle BEATS+4.
  - result_data is valid and done=1 in cycle BEATS+6, i.e. 22 for the defaults.
  - result_data holds until the next capture.
- Arithmetic: this block adds nothing. The tree's 16-bit wrap/saturation (0x7000 on carry-out) is passed through unchanged.

Optional Feature:
- Macro MODE4_FEEDER_HOLD_EN.
- When defined:
  - Adds input feed_hold (1 bit).
  - While feed_hold==1 in READ, rd_en=0 and rd_addr does not advance.
  - Already-issued run bits keep shifting, giving bubbles in the run enables.
  - DRAIN is entered only after all BEATS words have been issued.
  - done latency grows by the number of held READ cycles.
- When undefined: no feed_hold port; READ issues one word every cycle.

Test Plan:
- All 64 elements = 16'h0001, start at edge 0 -> rd_addr 0..15 in cycles 2..17; done in cycle 22; result_data=16'h0040.
- Element i = i, for i=0..63 -> result_data=16'h07E0.
- Two back-to-back vectors (ones, then all 16'h0002) -> tree_reset pulse before the second; second result=16'h0080, not 16'h00C0.
- start pulsed during READ and during DONE -> ignored; exactly one done per accepted start.
- reset driven low in cycle 10 of a run -> next cycle all outputs 0 with tree_reset=1; no done; a later start yields the correct sum.
- With MODE4_FEEDER_HOLD_EN, feed_hold high in cycles 5..7 -> rd_addr stalls, 3 bubbles in all three run enables, done in cycle 25, result unchanged (16'h0040 for all-ones).
